// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit add/subtract; the carry chain is split into STAGES chunks, one chunk per stage.
// Latency: a beat accepted on edge n shows out_valid after edge n+STAGES-1; throughput is one beat per cycle.
// Backpressure: combinational ready chain; bubbles collapse, and in_ready falls only when every stage holds a beat.
module pipe_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_add: WIDTH must be a multiple of STAGES and STAGES must lie in 1..WIDTH");
    end

    // Subtraction is folded into the operand: A - B == A + ~B + 1, so carry_in is overridden.
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign b_eff = sub ? ~in1 : in1;
    assign c0    = sub | carry_in;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] v;

    // Stage k may load when any stage at or after it is empty, or the consumer drains the output.
    // Written directly from v rather than from rdy[k+1] so the chain is not a self-referencing vector.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!v[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed when entering stage k.
        localparam int SW = WIDTH - k * CHUNK;

        logic [SW-1:0]          src_a;
        logic [SW-1:0]          src_b;
        logic                   src_c;
        logic                   src_v;
        logic [CHUNK:0]         add;
        logic [(k+1)*CHUNK-1:0] psum_nxt;
        logic [(k+1)*CHUNK-1:0] psum;
        logic                   carry;
        logic                   vld;

        if (k == 0) begin : g_first
            assign src_a    = in0;
            assign src_b    = b_eff;
            assign src_c    = c0;
            assign src_v    = in_valid;
            assign psum_nxt = add[CHUNK-1:0];
        end else begin : g_next
            assign src_a    = g_stage[k-1].g_mid.a_hi;
            assign src_b    = g_stage[k-1].g_mid.b_hi;
            assign src_c    = g_stage[k-1].carry;
            assign src_v    = g_stage[k-1].vld;
            assign psum_nxt = {add[CHUNK-1:0], g_stage[k-1].psum};
        end

        assign add = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, src_c};
        assign v[k] = vld;

        // Valid advances whenever the stage may load; data only moves with a real beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld   <= 1'b0;
                psum  <= '0;
                carry <= 1'b0;
            end else if (rdy[k]) begin
                vld <= src_v;
                if (src_v) begin
                    psum  <= psum_nxt;
                    carry <= add[CHUNK];
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [SW-CHUNK-1:0] a_hi;
            logic [SW-CHUNK-1:0] b_hi;

            // Carry the still-unprocessed upper operand chunks (including both MSBs) forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (rdy[k] && src_v) begin
                    a_hi <= src_a[SW-1:CHUNK];
                    b_hi <= src_b[SW-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf;

            // The top chunk holds both operand MSBs, so signed overflow is resolved here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf <= 1'b0;
                end else if (rdy[k] && src_v) begin
                    ovf <= (src_a[SW-1] == src_b[SW-1]) && (add[CHUNK-1] != src_a[SW-1]);
                end
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign sum       = g_stage[STAGES-1].psum;
    assign carry_out = g_stage[STAGES-1].carry;
    assign overflow  = g_stage[STAGES-1].g_last.ovf;

endmodule

// File: tb/tb_pipe_add.sv
// Directed and scoreboarded checks of pipe_add in three configurations (32/4, 8/1, 64/8).
// Latency is counted in edges after the accepting edge.
// Stalls are driven through out_ready; held outputs must stay stable.
module tb_pipe_add;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready, a_cout, a_ovf;
    logic [31:0] a_in0, a_in1, a_sum;

    logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [7:0]  b_in0, b_in1, b_sum;

    logic        c_in_valid, c_in_ready, c_cin, c_sub, c_out_valid, c_out_ready, c_cout, c_ovf;
    logic [63:0] c_in0, c_in1, c_sum;

    int tests = 0;
    int fails = 0;

    pipe_add #(.WIDTH(32), .STAGES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in0(a_in0), .in1(a_in1), .carry_in(a_cin), .sub(a_sub),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .sum(a_sum),
        .carry_out(a_cout), .overflow(a_ovf)
    );

    pipe_add #(.WIDTH(8), .STAGES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in0(b_in0), .in1(b_in1), .carry_in(b_cin), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sum(b_sum),
        .carry_out(b_cout), .overflow(b_ovf)
    );

    pipe_add #(.WIDTH(64), .STAGES(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in0(c_in0), .in1(c_in1), .carry_in(c_cin), .sub(c_sub),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .sum(c_sum),
        .carry_out(c_cout), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flat reference add: returns {overflow, carry_out, sum} for a w-bit operation.
    function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sb, input int w);
        logic [63:0] mask, be, s;
        logic [64:0] full;
        logic        c, o;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        be   = (sb ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, be} + {64'd0, (sb | cin)};
        c    = full[w];
        s    = full[63:0] & mask;
        o    = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
        return {o, c, s};
    endfunction

    // One beat through the 32/4 unit with out_ready high; reports acceptance, latency and result.
    task automatic beat32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb,
                          output logic [31:0] s, output logic c, output logic o,
                          output int lat, output logic acc);
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in0 = a; a_in1 = b; a_cin = cin; a_sub = sb; a_out_ready = 1'b1;
        #1 acc = a_in_ready;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = a_sum; c = a_cout; o = a_ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({a_out_valid, a_sum, a_cout, a_ovf, a_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_a: got vld=%b sum=%h c=%b o=%b rdy=%b, want vld=0 sum=00000000 c=0 o=0 rdy=1",
                     a_out_valid, a_sum, a_cout, a_ovf, a_in_ready);
        end
        tests++;
        if ({b_out_valid, b_sum, b_in_ready, c_out_valid, c_sum, c_in_ready} !== {1'b0, 8'h0, 1'b1, 1'b0, 64'h0, 1'b1}) begin
            fails++;
            $display("FAIL reset_bc: got b_vld=%b b_sum=%h b_rdy=%b c_vld=%b c_sum=%h c_rdy=%b, want 0 00 1 0 0 1",
                     b_out_valid, b_sum, b_in_ready, c_out_valid, c_sum, c_in_ready);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add_carry_chain();
        logic [31:0] s; logic c, o, acc; int lat;
        beat32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat, acc);
        tests++;
        if (acc !== 1'b1) begin
            fails++; $display("FAIL first_accept: in_ready=%b, want 1", acc);
        end
        tests++;
        if ({o, c, s} !== {1'b0, 1'b1, 32'h0000_0000}) begin
            fails++; $display("FAIL add_wrap: got o=%b c=%b sum=%h, want o=0 c=1 sum=00000000", o, c, s);
        end
        tests++;
        if (lat != 3) begin
            fails++; $display("FAIL latency_32x4: got %0d extra edges, want 3", lat);
        end
    endtask

    task automatic test_add_overflow();
        logic [31:0] s; logic c, o, acc; int lat;
        beat32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat, acc);
        tests++;
        if ({o, c, s} !== {1'b1, 1'b0, 32'h8000_0000}) begin
            fails++; $display("FAIL add_ovf: got o=%b c=%b sum=%h, want o=1 c=0 sum=80000000", o, c, s);
        end
    endtask

    task automatic test_sub();
        logic [31:0] s; logic c, o, acc; int lat;
        beat32(32'd5, 32'd7, 1'b1, 1'b1, s, c, o, lat, acc);
        tests++;
        if ({o, c, s} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
            fails++; $display("FAIL sub_borrow: got o=%b c=%b sum=%h, want o=0 c=0 sum=fffffffe", o, c, s);
        end
        beat32(32'h8000_0000, 32'd1, 1'b0, 1'b1, s, c, o, lat, acc);
        tests++;
        if ({o, c, s} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
            fails++; $display("FAIL sub_ovf: got o=%b c=%b sum=%h, want o=1 c=1 sum=7fffffff", o, c, s);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] exp_q[$];
        logic [33:0] held, exp_v;
        logic [65:0] r;
        logic [31:0] ra, rb;
        logic        rc, rs, hold_chk;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; hold_chk = 1'b0; held = '0;
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        while (got < 10 && cyc < 60) begin
            @(posedge clk); #1;
            a_in_valid  = (sent < 10);
            a_in0 = ra; a_in1 = rb; a_cin = rc; a_sub = rs;
            a_out_ready = !(cyc >= 3 && cyc <= 7);
            #1;
            if (hold_chk) begin
                tests++;
                if ({a_out_valid, a_ovf, a_cout, a_sum} !== {1'b1, held}) begin
                    fails++;
                    $display("FAIL bp_stable cyc%0d: got vld=%b %h, want vld=1 %h", cyc, a_out_valid,
                             {a_ovf, a_cout, a_sum}, held);
                end
            end
            hold_chk = a_out_valid && !a_out_ready;
            held     = {a_ovf, a_cout, a_sum};
            if (cyc == 5) begin
                tests++;
                if (a_in_ready !== 1'b0 || sent != 4) begin
                    fails++;
                    $display("FAIL bp_full: got in_ready=%b held=%0d, want in_ready=0 held=4", a_in_ready, sent);
                end
            end
            if (a_out_valid && a_out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL bp_result[%0d]: got unexpected beat %h, want none", got, held);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (held !== exp_v) begin
                        fails++; $display("FAIL bp_result[%0d]: got %h, want %h", got, held, exp_v);
                    end
                end
                got++;
            end
            if (a_in_valid && a_in_ready) begin
                r = ref_add({32'd0, ra}, {32'd0, rb}, rc, rs, 32);
                exp_q.push_back({r[65:64], r[31:0]});
                sent++;
                ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            end
            cyc++;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tests++;
        if (got != 10) begin
            fails++; $display("FAIL bp_count: got %0d results, want 10", got);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] s; logic c, o, acc, seen; int lat;
        a_out_ready = 1'b0; a_sub = 1'b0; a_cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1; a_in0 = 32'(i + 1); a_in1 = 32'h100;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (a_out_valid !== 1'b1) begin
            fails++; $display("FAIL mid_prefill: out_valid=%b, want 1", a_out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({a_out_valid, a_sum, a_in_ready} !== {1'b0, 32'h0, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset: got vld=%b sum=%h rdy=%b, want vld=0 sum=00000000 rdy=1",
                     a_out_valid, a_sum, a_in_ready);
        end
        @(posedge clk); #2;
        rst_n = 1'b1; a_out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | a_out_valid;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL mid_stale: out_valid seen=%b after release, want 0", seen);
        end
        beat32(32'h10, 32'h20, 1'b0, 1'b0, s, c, o, lat, acc);
        tests++;
        if ({o, c, s} !== {1'b0, 1'b0, 32'h30} || lat != 3) begin
            fails++; $display("FAIL mid_after: got o=%b c=%b sum=%h lat=%0d, want o=0 c=0 sum=00000030 lat=3",
                              o, c, s, lat);
        end
    endtask

    task automatic test_stages1();
        int lat; logic acc;
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in0 = 8'hFF; b_in1 = 8'h01; b_cin = 1'b1; b_sub = 1'b0; b_out_ready = 1'b1;
        #1 acc = b_in_ready;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if ({acc, b_ovf, b_cout, b_sum} !== {1'b1, 1'b0, 1'b1, 8'h01} || lat != 0) begin
            fails++;
            $display("FAIL s1_add: got acc=%b o=%b c=%b sum=%h lat=%0d, want acc=1 o=0 c=1 sum=01 lat=0",
                     acc, b_ovf, b_cout, b_sum, lat);
        end
    endtask

    task automatic test_random_64x8();
        logic [65:0] exp_q[$];
        logic [65:0] exp_v;
        logic        pend;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; pend = 1'b0;
        while (got < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (!pend && sent < 1000 && $urandom_range(0, 9) < 7) begin
                c_in0 = {$urandom, $urandom}; c_in1 = {$urandom, $urandom};
                c_cin = 1'($urandom); c_sub = 1'($urandom);
                pend = 1'b1;
            end
            c_in_valid  = pend;
            c_out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (c_out_valid && c_out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL r64_result[%0d]: got unexpected beat, want none", got);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({c_ovf, c_cout, c_sum} !== exp_v) begin
                        fails++;
                        $display("FAIL r64_result[%0d]: got %h, want %h", got, {c_ovf, c_cout, c_sum}, exp_v);
                    end
                end
                got++;
            end
            if (c_in_valid && c_in_ready) begin
                exp_q.push_back(ref_add(c_in0, c_in1, c_cin, c_sub, 64));
                sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        c_in_valid = 1'b0;
        tests++;
        if (got != 1000) begin
            fails++; $display("FAIL r64_count: got %0d results, want 1000", got);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in0 = '0; a_in1 = '0; a_cin = 1'b0; a_sub = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in0 = '0; b_in1 = '0; b_cin = 1'b0; b_sub = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in0 = '0; c_in1 = '0; c_cin = 1'b0; c_sub = 1'b0; c_out_ready = 1'b1;
        test_reset();
        test_add_carry_chain();
        test_add_overflow();
        test_sub();
        test_backpressure();
        test_reset_midstream();
        test_stages1();
        test_random_64x8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
